serial_subtractor_ctrl: RTL



---
 rtl/serial_sub_pkg.sv | 14 +
 rtl/fs_bit_cell.sv | 18 +
 rtl/serial_subtractor_ctrl.sv | 117 +++++++++++
 3 files changed

// File: rtl/serial_sub_pkg.sv
// Shared definitions for the bit-serial subtractor.
//   state_e       : controller states (IDLE, SHIFT, DONE)
//   DEFAULT_WIDTH : default operand width
package serial_sub_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/fs_bit_cell.sv
// Combinational 1-bit full subtractor: a - b - bin.
//   a, b, bin : operand bits and borrow-in
//   d         : difference bit
//   bo        : borrow-out
module fs_bit_cell (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bo
);

    assign d  = a ^ b ^ bin;
    // Borrow when b exceeds a outright, or when they are equal and a borrow
    // is already pending.
    assign bo = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor_ctrl.sv
// Bit-serial WIDTH-bit subtractor: sequences one fs_bit_cell over WIDTH
// cycles, LSB first, computing a - b - bin modulo 2^WIDTH.
//   clk, rst_n   : clock (rising edge), async active-low reset
//   start        : request; accepted in IDLE or DONE, ignored while busy
//   a, b, bin    : operands, sampled only on the accepting edge
//   busy         : high while bits are being processed
//   done         : one-cycle pulse when diff/bout are updated
//   diff, bout   : registered result, held until the next done
module serial_subtractor_ctrl
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
);

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   a_sh_q, a_sh_d;
    logic [WIDTH-1:0]   b_sh_q, b_sh_d;
    logic [WIDTH-1:0]   d_sh_q, d_sh_d;
    logic [WIDTH-1:0]   diff_q, diff_d;
    logic               borrow_q, borrow_d;
    logic               bout_q, bout_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic               cell_d;
    logic               cell_bo;
    logic [WIDTH-1:0]   d_sh_next;

    fs_bit_cell u_cell (
        .a   (a_sh_q[0]),
        .b   (b_sh_q[0]),
        .bin (borrow_q),
        .d   (cell_d),
        .bo  (cell_bo)
    );

    // New difference bit enters at the MSB; written as shift/or so that
    // WIDTH=1 needs no zero-width slice.
    assign d_sh_next = (d_sh_q >> 1) | (WIDTH'(cell_d) << (WIDTH - 1));

    always_comb begin
        state_d  = state_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        d_sh_d   = d_sh_q;
        diff_d   = diff_q;
        borrow_d = borrow_q;
        bout_d   = bout_q;
        cnt_d    = cnt_q;

        unique case (state_q)
            IDLE, DONE: begin
                // DONE lasts one cycle; a start here launches back-to-back.
                state_d = IDLE;
                if (start) begin
                    a_sh_d   = a;
                    b_sh_d   = b;
                    borrow_d = bin;
                    cnt_d    = '0;
                    state_d  = SHIFT;
                end
            end
            SHIFT: begin
                a_sh_d   = a_sh_q >> 1;
                b_sh_d   = b_sh_q >> 1;
                d_sh_d   = d_sh_next;
                borrow_d = cell_bo;
                cnt_d    = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    diff_d  = d_sh_next;
                    bout_d  = cell_bo;
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            d_sh_q   <= '0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
            bout_q   <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            d_sh_q   <= d_sh_d;
            diff_q   <= diff_d;
            borrow_q <= borrow_d;
            bout_q   <= bout_d;
            cnt_q    <= cnt_d;
        end
    end

    assign busy = (state_q == SHIFT);
    assign done = (state_q == DONE);
    assign diff = diff_q;
    assign bout = bout_q;

endmodule
